// File: rtl/game_flow_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : game_flow_ctrl
// Brief    : Title / player-select / play / over flow with frame timer and
//            per-player win tallies for the Bomberman top level.
// Revision : 1.0 - initial release
// =============================================================================
module game_flow_ctrl #(
    parameter int         NUM_PLAYERS  = 4,
    parameter int         ROUND_FRAMES = 10800,
    parameter int         SCORE_W      = 8,
    parameter int         WIN_SCORE    = 3,
    parameter logic [7:0] KEY_START    = 8'h28,
    parameter logic [7:0] KEY_UP       = 8'h52,
    parameter logic [7:0] KEY_DOWN     = 8'h51,
    parameter logic [7:0] KEY_BACK     = 8'h29
) (
    input  logic                                                       Clk,
    input  logic                                                       Reset_n,
    input  logic                                                       Frame_Clk,
    input  logic [15:0]                                                Keycode,
    input  logic [NUM_PLAYERS-1:0]                                     Player_Alive,
    output logic [1:0]                                                 state,
    output logic [$clog2(NUM_PLAYERS+1)-1:0]                           Player_choose,
    output logic [(($clog2(NUM_PLAYERS) > 1) ? $clog2(NUM_PLAYERS) : 1)-1:0] Winner,
    output logic                                                       Draw,
    output logic                                                       Match_Over,
    output logic                                                       Round_Reset,
    output logic                                                       Frame_Tick,
    output logic [$clog2(ROUND_FRAMES+1)-1:0]                          Timer,
    output logic [NUM_PLAYERS*SCORE_W-1:0]                             Wins
);

    localparam int c_PC_W  = $clog2(NUM_PLAYERS + 1);
    localparam int c_WIN_W = ($clog2(NUM_PLAYERS) > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam int c_TIM_W = $clog2(ROUND_FRAMES + 1);

    localparam logic [1:0] c_S_TITLE  = 2'b00;
    localparam logic [1:0] c_S_SELECT = 2'b01;
    localparam logic [1:0] c_S_PLAY   = 2'b10;
    localparam logic [1:0] c_S_OVER   = 2'b11;

    localparam logic [c_PC_W-1:0]  c_PC_MIN     = c_PC_W'(2);
    localparam logic [c_PC_W-1:0]  c_PC_MAX     = c_PC_W'(NUM_PLAYERS);
    localparam logic [c_PC_W-1:0]  c_CNT_ONE    = c_PC_W'(1);
    localparam logic [c_TIM_W-1:0] c_TIMER_LOAD = c_TIM_W'(ROUND_FRAMES);
    localparam logic [c_TIM_W-1:0] c_TIMER_ONE  = c_TIM_W'(1);
    localparam logic [SCORE_W-1:0] c_WIN_SCORE  = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] c_SCORE_ONE  = SCORE_W'(1);

    // Key vector bit order: [3] BACK, [2] START, [1] UP, [0] DOWN
    function automatic logic f_pressed(input logic [15:0] kc, input logic [7:0] key);
        return (kc[7:0] == key) || (kc[15:8] == key);
    endfunction

    logic [1:0]                            r_state, w_state_nxt;
    logic [c_PC_W-1:0]                     r_pc, w_pc_nxt;
    logic [c_WIN_W-1:0]                    r_winner, w_winner_nxt;
    logic                                  r_draw, w_draw_nxt;
    logic                                  r_round_reset, w_round_reset_nxt;
    logic [c_TIM_W-1:0]                    r_timer, w_timer_nxt;
    logic [NUM_PLAYERS-1:0][SCORE_W-1:0]   r_wins, w_wins_nxt;
    logic                                  r_grace, w_grace_nxt;
    logic                                  w_new_round;

    logic [2:0]                            r_fsync;
    logic                                  r_frame_tick;
    logic [3:0]                            r_key_prev;
    logic [3:0]                            w_press;
    logic [3:0]                            w_edge;
    logic                                  w_act_back, w_act_start, w_act_up, w_act_down;

    logic [NUM_PLAYERS-1:0]                w_active;
    logic [NUM_PLAYERS-1:0]                w_live;
    logic [NUM_PLAYERS-1:0]                w_reached;
    logic [c_PC_W-1:0]                     w_alive_cnt;
    logic [c_WIN_W-1:0]                    w_sole_idx;
    logic                                  w_match_over;

    assign w_press = {f_pressed(Keycode, KEY_BACK), f_pressed(Keycode, KEY_START),
                      f_pressed(Keycode, KEY_UP),   f_pressed(Keycode, KEY_DOWN)};
    assign w_edge  = w_press & ~r_key_prev;

    // Only the highest-priority new press is acted on
    assign w_act_back  = w_edge[3];
    assign w_act_start = w_edge[2] & ~w_edge[3];
    assign w_act_up    = w_edge[1] & ~(|w_edge[3:2]);
    assign w_act_down  = w_edge[0] & ~(|w_edge[3:1]);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
            assign w_active[gi]  = (c_PC_W'(gi) < r_pc);
            assign w_live[gi]    = w_active[gi] & Player_Alive[gi];
            assign w_reached[gi] = w_active[gi] & (r_wins[gi] >= c_WIN_SCORE);
        end
    endgenerate

    assign w_match_over = |w_reached;

    always_comb begin
        w_alive_cnt = '0;
        w_sole_idx  = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (w_live[i]) begin
                w_alive_cnt = w_alive_cnt + c_CNT_ONE;
                w_sole_idx  = c_WIN_W'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_winner_nxt      = r_winner;
        w_draw_nxt        = r_draw;
        w_timer_nxt       = r_timer;
        w_wins_nxt        = r_wins;
        w_grace_nxt       = r_grace;
        w_round_reset_nxt = 1'b0;
        w_new_round       = 1'b0;

        case (r_state)
            c_S_TITLE: begin
                if (w_act_start) begin
                    w_state_nxt = c_S_SELECT;
                end
            end
            c_S_SELECT: begin
                if (w_act_back) begin
                    w_state_nxt = c_S_TITLE;
                end else if (w_act_start) begin
                    w_new_round = 1'b1;
                end else if (w_act_up) begin
                    if (r_pc < c_PC_MAX) w_pc_nxt = r_pc + c_CNT_ONE;
                end else if (w_act_down) begin
                    if (r_pc > c_PC_MIN) w_pc_nxt = r_pc - c_CNT_ONE;
                end
            end
            c_S_PLAY: begin
                if (w_act_back) begin
                    w_state_nxt = c_S_TITLE;
                    w_wins_nxt  = '0;
                end else if (r_frame_tick) begin
                    if (r_grace) begin
                        // Avatars are still spawning: count time only
                        w_grace_nxt = 1'b0;
                        w_timer_nxt = r_timer - c_TIMER_ONE;
                        if (r_timer == c_TIMER_ONE) begin
                            w_draw_nxt  = 1'b1;
                            w_state_nxt = c_S_OVER;
                        end
                    end else if (w_alive_cnt == c_CNT_ONE) begin
                        w_winner_nxt = w_sole_idx;
                        w_draw_nxt   = 1'b0;
                        w_state_nxt  = c_S_OVER;
                        if (r_wins[w_sole_idx] != {SCORE_W{1'b1}}) begin
                            w_wins_nxt[w_sole_idx] = r_wins[w_sole_idx] + c_SCORE_ONE;
                        end
                    end else if (w_alive_cnt == '0) begin
                        w_draw_nxt  = 1'b1;
                        w_state_nxt = c_S_OVER;
                    end else begin
                        w_timer_nxt = r_timer - c_TIMER_ONE;
                        if (r_timer == c_TIMER_ONE) begin
                            w_draw_nxt  = 1'b1;
                            w_state_nxt = c_S_OVER;
                        end
                    end
                end
            end
            c_S_OVER: begin
                if (w_act_back) begin
                    w_state_nxt = c_S_TITLE;
                    w_wins_nxt  = '0;
                end else if (w_act_start) begin
                    if (w_match_over) begin
                        w_state_nxt = c_S_TITLE;
                        w_wins_nxt  = '0;
                    end else begin
                        w_new_round = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = c_S_TITLE;
            end
        endcase

        if (w_new_round) begin
            w_state_nxt       = c_S_PLAY;
            w_round_reset_nxt = 1'b1;
            w_timer_nxt       = c_TIMER_LOAD;
            w_draw_nxt        = 1'b0;
            w_grace_nxt       = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_fsync       <= '0;
            r_frame_tick  <= 1'b0;
            r_key_prev    <= '0;
            r_state       <= c_S_TITLE;
            r_pc          <= c_PC_MIN;
            r_winner      <= '0;
            r_draw        <= 1'b0;
            r_round_reset <= 1'b0;
            r_timer       <= '0;
            r_wins        <= '0;
            r_grace       <= 1'b0;
        end else begin
            // [0],[1] synchronise; [2] holds the previous synchronised level
            r_fsync       <= {r_fsync[1:0], Frame_Clk};
            r_frame_tick  <= r_fsync[1] & ~r_fsync[2];
            r_key_prev    <= w_press;
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_winner      <= w_winner_nxt;
            r_draw        <= w_draw_nxt;
            r_round_reset <= w_round_reset_nxt;
            r_timer       <= w_timer_nxt;
            r_wins        <= w_wins_nxt;
            r_grace       <= w_grace_nxt;
        end
    end

    assign state         = r_state;
    assign Player_choose = r_pc;
    assign Winner        = r_winner;
    assign Draw          = r_draw;
    assign Match_Over    = w_match_over;
    assign Round_Reset   = r_round_reset;
    assign Frame_Tick    = r_frame_tick;
    assign Timer         = r_timer;
    assign Wins          = r_wins;

endmodule
`default_nettype wire

// File: tb/tb_game_flow_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_game_flow_ctrl
// Brief    : Self-checking bench for game_flow_ctrl (full-length and short-round
//            instances sharing one stimulus stream).
// Revision : 1.0 - initial release
// =============================================================================
module tb_game_flow_ctrl;

    localparam int NP  = 4;
    localparam int RF0 = 10800;
    localparam int RF1 = 4;
    localparam int SW  = 8;
    localparam int WS  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fclk;
    logic [15:0] kc;
    logic [3:0]  alive;

    logic [1:0]  w_state  [2];
    logic [2:0]  w_pc     [2];
    logic [1:0]  w_winner [2];
    logic        w_draw   [2];
    logic        w_mo     [2];
    logic        w_rr     [2];
    logic        w_ft     [2];
    logic [31:0] w_wins   [2];
    logic [13:0] w_timer0;
    logic [2:0]  w_timer1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    game_flow_ctrl #(.NUM_PLAYERS(NP), .ROUND_FRAMES(RF0), .SCORE_W(SW), .WIN_SCORE(WS)) dut (
        .Clk(clk), .Reset_n(rst_n), .Frame_Clk(fclk), .Keycode(kc), .Player_Alive(alive),
        .state(w_state[0]), .Player_choose(w_pc[0]), .Winner(w_winner[0]), .Draw(w_draw[0]),
        .Match_Over(w_mo[0]), .Round_Reset(w_rr[0]), .Frame_Tick(w_ft[0]), .Timer(w_timer0),
        .Wins(w_wins[0])
    );

    game_flow_ctrl #(.NUM_PLAYERS(NP), .ROUND_FRAMES(RF1), .SCORE_W(SW), .WIN_SCORE(WS)) dut_s (
        .Clk(clk), .Reset_n(rst_n), .Frame_Clk(fclk), .Keycode(kc), .Player_Alive(alive),
        .state(w_state[1]), .Player_choose(w_pc[1]), .Winner(w_winner[1]), .Draw(w_draw[1]),
        .Match_Over(w_mo[1]), .Round_Reset(w_rr[1]), .Frame_Tick(w_ft[1]), .Timer(w_timer1),
        .Wins(w_wins[1])
    );

    // Reference model: one record per instance, flow states named by their output code
    localparam int TITLE = 0, SELECT = 1, PLAY = 2, OVER = 3;
    localparam int K_BACK = 0, K_START = 1, K_UP = 2, K_DOWN = 3;

    int         m_state [2];
    int         m_pc    [2];
    int         m_winner[2];
    int         m_draw  [2];
    int         m_rr    [2];
    int         m_timer [2];
    int         m_grace [2];
    int         m_wins  [2][NP];
    int         m_tick;
    int         fhist   [4];
    int         kprev   [4];
    int         rf      [2];
    logic [7:0] kcode   [4];

    function automatic int m_match(input int m);
        for (int i = 0; i < m_pc[m]; i++) if (m_wins[m][i] >= WS) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        rf[0] = RF0; rf[1] = RF1;
        kcode[K_BACK] = 8'h29; kcode[K_START] = 8'h28; kcode[K_UP] = 8'h52; kcode[K_DOWN] = 8'h51;
        for (int m = 0; m < 2; m++) begin
            m_state[m] = TITLE; m_pc[m] = 2; m_winner[m] = 0; m_draw[m] = 0;
            m_rr[m] = 0; m_timer[m] = 0; m_grace[m] = 0;
            for (int i = 0; i < NP; i++) m_wins[m][i] = 0;
        end
        m_tick = 0;
        for (int j = 0; j < 4; j++) begin fhist[j] = 0; kprev[j] = 0; end
    endtask

    // Advance the model by one clock with the inputs the DUT samples at that edge
    task automatic model_step(input logic [15:0] k, input logic f, input logic [3:0] a);
        int now[4];
        int act;
        int n;
        int who;
        int start_round;
        act = -1;
        for (int j = 0; j < 4; j++) begin
            now[j] = ((k[7:0] == kcode[j]) || (k[15:8] == kcode[j])) ? 1 : 0;
            if (act < 0 && now[j] == 1 && kprev[j] == 0) act = j;
        end
        for (int m = 0; m < 2; m++) begin
            start_round = 0;
            m_rr[m] = 0;
            n = 0; who = 0;
            for (int i = 0; i < m_pc[m]; i++) if (a[i]) begin n++; who = i; end
            case (m_state[m])
                TITLE:  if (act == K_START) m_state[m] = SELECT;
                SELECT: begin
                    if (act == K_BACK) m_state[m] = TITLE;
                    else if (act == K_START) start_round = 1;
                    else if (act == K_UP && m_pc[m] < NP) m_pc[m]++;
                    else if (act == K_DOWN && m_pc[m] > 2) m_pc[m]--;
                end
                PLAY: begin
                    if (act == K_BACK) begin
                        m_state[m] = TITLE;
                        for (int i = 0; i < NP; i++) m_wins[m][i] = 0;
                    end else if (m_tick == 1) begin
                        if (m_grace[m] == 1) begin
                            m_grace[m] = 0;
                            m_timer[m]--;
                            if (m_timer[m] == 0) begin m_draw[m] = 1; m_state[m] = OVER; end
                        end else if (n == 1) begin
                            m_winner[m] = who; m_draw[m] = 0; m_state[m] = OVER;
                            if (m_wins[m][who] < 255) m_wins[m][who]++;
                        end else if (n == 0) begin
                            m_draw[m] = 1; m_state[m] = OVER;
                        end else begin
                            m_timer[m]--;
                            if (m_timer[m] == 0) begin m_draw[m] = 1; m_state[m] = OVER; end
                        end
                    end
                end
                default: begin
                    if (act == K_BACK || (act == K_START && m_match(m) == 1)) begin
                        m_state[m] = TITLE;
                        for (int i = 0; i < NP; i++) m_wins[m][i] = 0;
                    end else if (act == K_START) start_round = 1;
                end
            endcase
            if (start_round == 1) begin
                m_state[m] = PLAY; m_rr[m] = 1; m_timer[m] = rf[m]; m_draw[m] = 0; m_grace[m] = 1;
            end
        end
        for (int j = 0; j < 4; j++) kprev[j] = now[j];
        fhist[3] = fhist[2]; fhist[2] = fhist[1]; fhist[1] = fhist[0]; fhist[0] = f ? 1 : 0;
        m_tick = (fhist[2] == 1 && fhist[3] == 0) ? 1 : 0;
    endtask

    // One clock: drive inputs, advance the model, land 1 time unit past the edge
    task automatic cyc(input logic [15:0] k, input logic f, input logic [3:0] a);
        kc = k; fclk = f; alive = a;
        if (rst_n) model_step(k, f, a); else model_reset();
        @(posedge clk); #1;
    endtask

    task automatic press(input logic [15:0] k, input logic [3:0] a);
        cyc(k, 1'b0, a);
        cyc(16'h0000, 1'b0, a);
    endtask

    task automatic frame_pulse(input logic [3:0] a);
        cyc(16'h0000, 1'b1, a);
        cyc(16'h0000, 1'b1, a);
        cyc(16'h0000, 1'b0, a);
        cyc(16'h0000, 1'b0, a);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; kc = '0; fclk = 1'b0; alive = '1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (w_state[0] !== 2'b00) begin bad++; $display("FAIL reset_state got=%0d want=0", w_state[0]); end
        total++; if (w_pc[0] !== 3'd2) begin bad++; $display("FAIL reset_pc got=%0d want=2", w_pc[0]); end
        total++; if ({w_winner[0], w_draw[0], w_mo[0], w_rr[0], w_ft[0]} !== 6'b0)
            begin bad++; $display("FAIL reset_flags got=%b want=000000", {w_winner[0], w_draw[0], w_mo[0], w_rr[0], w_ft[0]}); end
        total++; if (w_timer0 !== 14'd0 || w_wins[0] !== 32'd0)
            begin bad++; $display("FAIL reset_timer_wins got=%0d/%h want=0/0", w_timer0, w_wins[0]); end
    endtask

    task automatic test_select();
        int exp_up[3];
        int exp_dn[3];
        exp_up = '{3, 4, 4};
        exp_dn = '{3, 2, 2};
        do_reset();
        cyc(16'h0028, 1'b0, '1);
        total++; if (w_state[0] !== 2'b01) begin bad++; $display("FAIL title_start got=%0d want=1", w_state[0]); end
        cyc(16'h0000, 1'b0, '1);
        for (int i = 0; i < 3; i++) begin
            cyc(16'h0052, 1'b0, '1);
            total++; if (w_pc[0] !== 3'(exp_up[i])) begin bad++; $display("FAIL select_up%0d got=%0d want=%0d", i, w_pc[0], exp_up[i]); end
            cyc(16'h0000, 1'b0, '1);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(16'h0051, 1'b0, '1);
            total++; if (w_pc[0] !== 3'(exp_dn[i])) begin bad++; $display("FAIL select_down%0d got=%0d want=%0d", i, w_pc[0], exp_dn[i]); end
            cyc(16'h0000, 1'b0, '1);
        end
    endtask

    task automatic test_play_timer();
        cyc(16'h0028, 1'b0, '1);
        total++; if (w_state[0] !== 2'b10 || w_rr[0] !== 1'b1 || w_timer0 !== 14'd10800)
            begin bad++; $display("FAIL play_entry got=%0d/%0d/%0d want=2/1/10800", w_state[0], w_rr[0], w_timer0); end
        cyc(16'h0000, 1'b0, '1);
        total++; if (w_rr[0] !== 1'b0) begin bad++; $display("FAIL round_reset_width got=%0d want=0", w_rr[0]); end
        for (int p = 0; p < 5; p++) begin
            cyc(16'h0000, 1'b1, '1);
            cyc(16'h0000, 1'b1, '1);
            total++; if (w_ft[0] !== 1'b0) begin bad++; $display("FAIL tick_early%0d got=%0d want=0", p, w_ft[0]); end
            cyc(16'h0000, 1'b0, '1);
            total++; if (w_ft[0] !== 1'b1) begin bad++; $display("FAIL tick_at3_%0d got=%0d want=1", p, w_ft[0]); end
            cyc(16'h0000, 1'b0, '1);
            total++; if (w_ft[0] !== 1'b0) begin bad++; $display("FAIL tick_len%0d got=%0d want=0", p, w_ft[0]); end
        end
        total++; if (w_timer0 !== 14'd10795) begin bad++; $display("FAIL timer_5ticks got=%0d want=10795", w_timer0); end
    endtask

    task automatic test_winner();
        do_reset();
        press(16'h0028, '1);
        press(16'h0052, '1);
        press(16'h0028, '1);
        frame_pulse(4'b1111);
        frame_pulse(4'b1010);
        total++; if (w_state[0] !== 2'b11 || w_winner[0] !== 2'd1 || w_draw[0] !== 1'b0)
            begin bad++; $display("FAIL sole_survivor got=%0d/%0d/%0d want=3/1/0", w_state[0], w_winner[0], w_draw[0]); end
        total++; if (w_wins[0] !== 32'h0000_0100) begin bad++; $display("FAIL wins_p1 got=%h want=00000100", w_wins[0]); end
    endtask

    task automatic test_timeout();
        do_reset();
        press(16'h0028, '1);
        press(16'h0028, '1);
        repeat (4) frame_pulse(4'b0011);
        total++; if (w_state[1] !== 2'b11 || w_draw[1] !== 1'b1 || w_timer1 !== 3'd0)
            begin bad++; $display("FAIL timeout_draw got=%0d/%0d/%0d want=3/1/0", w_state[1], w_draw[1], w_timer1); end
        do_reset();
        press(16'h0028, '1);
        press(16'h0028, '1);
        repeat (3) frame_pulse(4'b0011);
        frame_pulse(4'b0001);
        total++; if (w_state[1] !== 2'b11 || w_winner[1] !== 2'd0 || w_draw[1] !== 1'b0 || w_wins[1] !== 32'd1)
            begin bad++; $display("FAIL survivor_beats_timeout got=%0d/%0d/%0d/%h want=3/0/0/1", w_state[1], w_winner[1], w_draw[1], w_wins[1]); end
    endtask

    task automatic test_match();
        do_reset();
        press(16'h0028, '1);
        press(16'h0052, '1);
        press(16'h0028, '1);
        for (int r = 0; r < 3; r++) begin
            frame_pulse(4'b1111);
            frame_pulse(4'b0100);
            total++; if (w_wins[0] !== 32'((r + 1) << 16) || w_mo[0] !== (r == 2))
                begin bad++; $display("FAIL match_round%0d got=%h/%0d want=%h/%0d", r, w_wins[0], w_mo[0], (r + 1) << 16, r == 2); end
            if (r < 2) press(16'h0028, '1);
        end
        press(16'h0028, '1);
        total++; if (w_state[0] !== 2'b00 || w_wins[0] !== 32'd0 || w_winner[0] !== 2'd2)
            begin bad++; $display("FAIL match_end got=%0d/%h/%0d want=0/0/2", w_state[0], w_wins[0], w_winner[0]); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] prev_s;
        int         changes;
        do_reset();
        press(16'h0028, '1);
        cyc(16'h2852, 1'b0, '1);
        total++; if (w_state[0] !== 2'b10 || w_pc[0] !== 3'd2)
            begin bad++; $display("FAIL start_beats_up got=%0d/%0d want=2/2", w_state[0], w_pc[0]); end
        cyc(16'h0000, 1'b0, '1);
        do_reset();
        changes = 0;
        prev_s = w_state[0];
        for (int i = 0; i < 100; i++) begin
            cyc(16'h0028, 1'b0, '1);
            if (w_state[0] != prev_s) changes++;
            prev_s = w_state[0];
        end
        total++; if (changes != 1 || w_state[0] !== 2'b01)
            begin bad++; $display("FAIL held_key got=%0d changes,state %0d want=1,1", changes, w_state[0]); end
        cyc(16'h0000, 1'b0, '1);
    endtask

    task automatic test_async_reset();
        do_reset();
        press(16'h0028, '1);
        press(16'h0052, '1);
        press(16'h0028, '1);
        frame_pulse(4'b1111);
        frame_pulse(4'b1010);
        press(16'h0028, '1);
        frame_pulse(4'b1111);
        cyc(16'h0052, 1'b1, '1);
        #2 rst_n = 1'b0;
        #1;
        total++; if (w_state[0] !== 2'b00 || w_pc[0] !== 3'd2 || w_winner[0] !== 2'd0 || w_draw[0] !== 1'b0)
            begin bad++; $display("FAIL async_state got=%0d/%0d/%0d/%0d want=0/2/0/0", w_state[0], w_pc[0], w_winner[0], w_draw[0]); end
        total++; if (w_timer0 !== 14'd0 || w_wins[0] !== 32'd0 || w_mo[0] !== 1'b0 || w_rr[0] !== 1'b0 || w_ft[0] !== 1'b0)
            begin bad++; $display("FAIL async_data got=%0d/%h/%0d/%0d/%0d want=0/0/0/0/0", w_timer0, w_wins[0], w_mo[0], w_rr[0], w_ft[0]); end
        cyc(16'h0000, 1'b0, '1);
        rst_n = 1'b1;
        cyc(16'h0000, 1'b0, '1);
        total++; if (w_state[0] !== 2'b00 || w_rr[0] !== 1'b0)
            begin bad++; $display("FAIL async_release got=%0d/%0d want=0/0", w_state[0], w_rr[0]); end
    endtask

    task automatic test_random();
        logic [15:0] k;
        logic [31:0] ew;
        logic        f;
        logic [3:0]  a;
        int          sel;
        do_reset();
        f = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            sel = $urandom_range(0, 11);
            case (sel)
                6:       k = 16'h0028;
                7:       k = 16'h0052;
                8:       k = 16'h5100;
                9:       k = ($urandom_range(0, 3) == 0) ? 16'h0029 : 16'h0000;
                10:      k = 16'($urandom);
                11:      k = 16'h5228;
                default: k = 16'h0000;
            endcase
            if ($urandom_range(0, 2) == 0) f = ~f;
            a = ($urandom_range(0, 3) != 0) ? 4'b1111 : 4'($urandom);
            cyc(k, f, a);
            for (int m = 0; m < 2; m++) begin
                ew = '0;
                for (int i = 0; i < NP; i++) ew[i*SW +: SW] = SW'(m_wins[m][i]);
                total++; if (w_state[m] !== 2'(m_state[m]) || w_pc[m] !== 3'(m_pc[m]))
                    begin bad++; $display("FAIL rnd_state_pc dut%0d cyc%0d got=%0d/%0d want=%0d/%0d", m, c, w_state[m], w_pc[m], m_state[m], m_pc[m]); end
                total++; if (w_winner[m] !== 2'(m_winner[m]) || w_draw[m] !== 1'(m_draw[m]) || w_mo[m] !== 1'(m_match(m)))
                    begin bad++; $display("FAIL rnd_result dut%0d cyc%0d got=%0d/%0d/%0d want=%0d/%0d/%0d", m, c, w_winner[m], w_draw[m], w_mo[m], m_winner[m], m_draw[m], m_match(m)); end
                total++; if (w_rr[m] !== 1'(m_rr[m]) || w_ft[m] !== 1'(m_tick))
                    begin bad++; $display("FAIL rnd_pulses dut%0d cyc%0d got=%0d/%0d want=%0d/%0d", m, c, w_rr[m], w_ft[m], m_rr[m], m_tick); end
                total++; if (w_wins[m] !== ew)
                    begin bad++; $display("FAIL rnd_wins dut%0d cyc%0d got=%h want=%h", m, c, w_wins[m], ew); end
            end
            total++; if (w_timer0 !== 14'(m_timer[0]) || w_timer1 !== 3'(m_timer[1]))
                begin bad++; $display("FAIL rnd_timer cyc%0d got=%0d/%0d want=%0d/%0d", c, w_timer0, w_timer1, m_timer[0], m_timer[1]); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; kc = '0; fclk = 1'b0; alive = '1;
        test_reset();
        test_select();
        test_play_timer();
        test_winner();
        test_timeout();
        test_match();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Parametrised game-flow controller for the Bomberman top level. It replaces the constant state, Player_choose and Winner ties with a real flow: title, player-count select, round play, round over and match over. It supports 2..NUM_PLAYERS players, keyboard-driven menus, a per-round frame timer and per-player win tallies. It sits between the NIOS keycode export and VGA_VS on the input side, and Game_Hub / Color_Mapper_Final on the output side.

Parameters:
NUM_PLAYERS, 4, maximum players supported (2..8)
ROUND_FRAMES, 10800, round length in frames (180 s at 60 Hz)
SCORE_W, 8, width of each per-player win counter
WIN_SCORE, 3, round wins that end the match
KEY_START, 8'h28, USB HID usage for Enter (start/confirm)
KEY_UP, 8'h52, HID usage for Up arrow (player count +1)
KEY_DOWN, 8'h51, HID usage for Down arrow (player count -1)
KEY_BACK, 8'h29, HID usage for Escape (abort to title)

Ports:
Clk  in  1  system clock (CLOCK_50)
Reset_n  in  1  asynchronous, active-low reset
Frame_Clk  in  1  VGA_VS, frame strobe
Keycode  in  16  two HID keycodes: [7:0] and [15:8]; 8'h00 means no key
Player_Alive  in  NUM_PLAYERS  alive flags from Game_Hub, bit i = player i
state  out  2  00 TITLE, 01 SELECT, 10 PLAY, 11 OVER
Player_choose  out  $clog2(NUM_PLAYERS+1)  selected player count
Winner  out  max(1,$clog2(NUM_PLAYERS))  index of the last round winner
Draw  out  1  last round ended with no single survivor
Match_Over  out  1  a player's win counter has reached WIN_SCORE
Round_Reset  out  1  one-Clk pulse; Game_Hub reloads the map and avatars
Frame_Tick  out  1  one-Clk pulse per rising edge of Frame_Clk
Timer  out  $clog2(ROUND_FRAMES+1)  frames remaining in the round
Wins  out  NUM_PLAYERS*SCORE_W  packed win counters; player i at [i*SCORE_W +: SCORE_W]

Behaviour:
- Reset (async assert, sync release):
  - state=00, Player_choose=2, Winner=0, Draw=0, Match_Over=0.
  - Round_Reset=0, Frame_Tick=0, Timer=0, Wins=0.
  - Synchronisers and key-history registers cleared.
  - Reset mid-round abandons the round immediately. No Round_Reset pulse is issued.
- Frame_Clk: 2-FF synchroniser, then rising-edge detect. Frame_Tick asserts 3 Clk cycles after the Frame_Clk rise and lasts exactly 1 cycle.
- Key events:
  - Key K is pressed when Keycode[7:0]==K or Keycode[15:8]==K.
  - An event fires on the first Clk cycle where K is pressed and was not pressed the previous cycle. Holding a key yields one event.
  - Several distinct key events in the same cycle: priority BACK > START > UP > DOWN. Only one is acted on.
- TITLE: START -> SELECT. All other keys are ignored.
- SELECT:
  - UP: Player_choose+1, saturating at NUM_PLAYERS.
  - DOWN: Player_choose-1, saturating at 2.
  - START -> PLAY: pulse Round_Reset, load Timer=ROUND_FRAMES, clear Draw.
  - BACK -> TITLE.
- PLAY:
  - Only players with index < Player_choose count as active.
  - The first Frame_Tick after entry is a grace tick: Timer decrements, survivors are not evaluated. Evaluation runs on every later Frame_Tick, using Player_Alive sampled that cycle.
  - Exactly one active survivor: Winner=its index, Draw=0, its Wins+1 (saturating at 2^SCORE_W-1), go to OVER.
  - Zero active survivors: Draw=1, Winner unchanged, go to OVER.
  - Otherwise the tick decrements Timer. If Timer goes 1->0 on that tick: Draw=1, go to OVER.
  - Same-tick priority: the survivor check beats timeout, so a sole survivor on the tick Timer reaches 0 wins.
  - BACK -> TITLE and clears Wins.
- Match_Over is combinational on the registered Wins: 1 when any active player's Wins >= WIN_SCORE.
- OVER: Timer holds its value.
  - START with Match_Over=0 -> PLAY: Round_Reset pulse, Timer reload, Player_choose kept.
  - START with Match_Over=1 -> TITLE: Wins cleared, Winner and Draw kept until the next round ends.
  - BACK -> TITLE: Wins cleared.
- Round_Reset asserts in the cycle after the START event, i.e. the same cycle state first reads 10.
- Player_choose changes only in SELECT, so it is stable throughout PLAY and OVER.

Test Plan:
- Reset then Keycode=0x0028 for 1 cycle -> state 00->01. Then UP x3 (0x0052, each released between presses) -> Player_choose 3,4,4 (saturates). Then DOWN x3 -> 3,2,2.
- SELECT, Player_choose=2, START -> state=10, single-cycle Round_Reset, Timer=10800. Then pulse Frame_Clk 5 times -> 5 single-cycle Frame_Ticks, each 3 cycles after its Frame_Clk rise, and Timer=10795.
- PLAY, Player_choose=3, Player_Alive=4'b1010 (bit3 inactive) on a non-grace tick -> state=11, Winner=1, Draw=0, Wins[1]=1.
- PLAY with ROUND_FRAMES=4 and Player_Alive=4'b0011 on every tick -> after the 4th tick state=11, Draw=1, Timer=0. Repeat with Player_Alive=4'b0001 on the 4th tick -> Winner=0, Draw=0.
- Player 2 wins 3 rounds (START from OVER between rounds) -> Match_Over=1 after the 3rd. Next START -> state=00, Wins=0.
- Keycode=0x2852 (START and UP together) in SELECT -> PLAY entered, Player_choose unchanged. Hold 0x0028 for 100 cycles -> only one transition. Deassert Reset_n mid-PLAY -> all outputs at reset values asynchronously.
